// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the RISC CPU instruction sequencer: opcodes,
// sequencer state encodings and the control strobe bundle.
package cpu_defs_pkg;

    localparam logic [2:0] OP_HLT  = 3'b000;
    localparam logic [2:0] OP_SKZ  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_ANDD = 3'b011;
    localparam logic [2:0] OP_XORR = 3'b100;
    localparam logic [2:0] OP_LDA  = 3'b101;
    localparam logic [2:0] OP_STO  = 3'b110;
    localparam logic [2:0] OP_JMP  = 3'b111;

    typedef enum logic [2:0] {
        S_FETCH_HI = 3'd0,
        S_FETCH_LO = 3'd1,
        S_DECODE   = 3'd2,
        S_EXEC1    = 3'd3,
        S_EXEC2    = 3'd4,
        S_EXEC3    = 3'd5,
        S_EXEC4    = 3'd6,
        S_WRAP     = 3'd7
    } state_t;

    // Strobes produced by the decoder; halt is owned by the state register.
    localparam int CTL_W = 7;

    typedef struct packed {
        logic load_ir;
        logic rd;
        logic wr;
        logic inc_pc;
        logic load_pc;
        logic load_acc;
        logic datactl_ena;
    } ctl_t;

endpackage

// File: rtl/machine_ctl_if.sv
// Control bus between the start logic / instruction register and the
// sequencer, plus the strobes the sequencer drives into the datapath.
interface machine_ctl_if;
    logic       ena;
    logic [2:0] opcode;
    logic       zero;
    logic       load_ir;
    logic       rd;
    logic       wr;
    logic       inc_pc;
    logic       load_pc;
    logic       load_acc;
    logic       datactl_ena;
    logic       halt;

    modport master (
        output ena, opcode, zero,
        input  load_ir, rd, wr, inc_pc, load_pc, load_acc, datactl_ena, halt
    );

    modport slave (
        input  ena, opcode, zero,
        output load_ir, rd, wr, inc_pc, load_pc, load_acc, datactl_ena, halt
    );
endinterface

// File: rtl/machine_ctl_decode.sv
// Combinational strobe decode of sequencer state, opcode and zero flag.
// When active is low every strobe is held at 0.
module machine_ctl_decode
    import cpu_defs_pkg::*;
(
    input  state_t     state,
    input  logic [2:0] opcode,
    input  logic       zero,
    input  logic       active,
    output ctl_t       ctl
);

    logic is_alu;
    logic is_sto;
    logic is_jmp;
    logic skz_taken;

    assign is_alu    = (opcode == OP_ADD) || (opcode == OP_ANDD) ||
                       (opcode == OP_XORR) || (opcode == OP_LDA);
    assign is_sto    = (opcode == OP_STO);
    assign is_jmp    = (opcode == OP_JMP);
    assign skz_taken = (opcode == OP_SKZ) && zero;

    always_comb begin
        ctl = '0;
        if (active) begin
            case (state)
                S_FETCH_HI, S_FETCH_LO: begin
                    ctl.load_ir = 1'b1;
                    ctl.rd      = 1'b1;
                    ctl.inc_pc  = 1'b1;
                end
                S_EXEC2: begin
                    ctl.rd          = is_alu;
                    ctl.datactl_ena = is_sto;
                    ctl.load_pc     = is_jmp;
                    ctl.inc_pc      = skz_taken;
                end
                // wr sits one cycle inside the datactl_ena window on both sides.
                S_EXEC3: begin
                    ctl.rd          = is_alu;
                    ctl.load_acc    = is_alu;
                    ctl.datactl_ena = is_sto;
                    ctl.wr          = is_sto;
                    ctl.load_pc     = is_jmp;
                    ctl.inc_pc      = skz_taken;
                end
                S_EXEC4: begin
                    ctl.datactl_ena = is_sto;
                end
                default: ctl = '0;
            endcase
        end
    end

endmodule

// File: rtl/machine_ctl.sv
// Eight-cycle instruction sequencer: state register and sticky halt flag,
// with strobes decoded combinationally in machine_ctl_decode.
//
// state | meaning
// S0    | fetch instruction high byte
// S1    | fetch instruction low byte
// S2    | decode, opcode settling
// S3    | exec1, HLT latches halt here
// S4    | exec2, operand read / bus drive / jump / skip
// S5    | exec3, accumulator load / write / jump / skip
// S6    | exec4, store bus hold
// S7    | wrap to next fetch
module machine_ctl
    import cpu_defs_pkg::*;
(
    input  logic          clk1,
    input  logic          rst,
    machine_ctl_if.slave  bus
);

    state_t state;
    logic   halt_q;
    logic   active;
    ctl_t   ctl;

    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            state  <= S_FETCH_HI;
            halt_q <= 1'b0;
        end else if (halt_q) begin
            state  <= S_EXEC1;
        end else if (!bus.ena) begin
            state  <= S_FETCH_HI;
        end else if (state == S_EXEC1 && bus.opcode == OP_HLT) begin
            halt_q <= 1'b1;
        end else begin
            state  <= state_t'(state + 3'd1);
        end
    end

    // Gating on rst keeps strobes quiet during reset independent of state.
    assign active = rst & bus.ena & ~halt_q;

    machine_ctl_decode u_decode (
        .state  (state),
        .opcode (bus.opcode),
        .zero   (bus.zero),
        .active (active),
        .ctl    (ctl)
    );

    assign bus.load_ir     = ctl.load_ir;
    assign bus.rd          = ctl.rd;
    assign bus.wr          = ctl.wr;
    assign bus.inc_pc      = ctl.inc_pc;
    assign bus.load_pc     = ctl.load_pc;
    assign bus.load_acc    = ctl.load_acc;
    assign bus.datactl_ena = ctl.datactl_ena;
    assign bus.halt        = halt_q;

endmodule

// File: tb/tb_machine_ctl.sv
// Self-checking bench for machine_ctl: table of per-instruction strobe
// sequences plus hand-written halt, enable-drop and reset-pulse sequences.
module tb_machine_ctl;

    // {halt, load_ir, rd, wr, inc_pc, load_pc, load_acc, datactl_ena}
    localparam logic [7:0] Z  = 8'h00;
    localparam logic [7:0] F  = 8'h68;
    localparam logic [7:0] R  = 8'h20;
    localparam logic [7:0] RA = 8'h22;
    localparam logic [7:0] D  = 8'h01;
    localparam logic [7:0] DW = 8'h11;
    localparam logic [7:0] J  = 8'h04;
    localparam logic [7:0] I  = 8'h08;
    localparam logic [7:0] H  = 8'h80;

    typedef struct {
        string      name;
        logic [2:0] op;
        logic       zero;
        logic [7:0] exp [8];
        int         inc;
    } vec_t;

    logic clk1;
    logic rst;
    int   n_chk;
    int   n_fail;
    logic [7:0] sb [$];
    logic [7:0] act;
    vec_t tbl [9];

    machine_ctl_if bus ();

    machine_ctl dut (
        .clk1 (clk1),
        .rst  (rst),
        .bus  (bus)
    );

    assign act = {bus.halt, bus.load_ir, bus.rd, bus.wr, bus.inc_pc,
                  bus.load_pc, bus.load_acc, bus.datactl_ena};

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    task automatic chk_int(input string nm, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Queue the expectation, let combinational outputs settle, then compare.
    task automatic probe(input string nm, input logic [7:0] exp);
        logic [7:0] e;
        sb.push_back(exp);
        #1;
        e = sb.pop_front();
        n_chk++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, e, $time);
        end
    endtask

    task automatic step(input string nm, input logic [7:0] exp);
        probe(nm, exp);
        @(negedge clk1);
    endtask

    task automatic run_vec(input int i);
        int incs;
        incs = 0;
        bus.opcode = tbl[i].op;
        bus.zero   = tbl[i].zero;
        for (int c = 0; c < 8; c++) begin
            probe($sformatf("%s_s%0d", tbl[i].name, c), tbl[i].exp[c]);
            incs += int'(act[3]);
            @(negedge clk1);
        end
        chk_int({tbl[i].name, "_inc_pc_count"}, incs, tbl[i].inc);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        tbl[0] = '{"lda",   3'b101, 1'b0, '{F, F, Z, Z, R,  RA, Z, Z}, 2};
        tbl[1] = '{"sto",   3'b110, 1'b0, '{F, F, Z, Z, D,  DW, D, Z}, 2};
        tbl[2] = '{"skz_t", 3'b001, 1'b1, '{F, F, Z, Z, I,  I,  Z, Z}, 4};
        tbl[3] = '{"skz_n", 3'b001, 1'b0, '{F, F, Z, Z, Z,  Z,  Z, Z}, 2};
        tbl[4] = '{"jmp",   3'b111, 1'b1, '{F, F, Z, Z, J,  J,  Z, Z}, 2};
        tbl[5] = '{"add",   3'b010, 1'b1, '{F, F, Z, Z, R,  RA, Z, Z}, 2};
        tbl[6] = '{"andd",  3'b011, 1'b0, '{F, F, Z, Z, R,  RA, Z, Z}, 2};
        tbl[7] = '{"xorr",  3'b100, 1'b1, '{F, F, Z, Z, R,  RA, Z, Z}, 2};
        tbl[8] = '{"sto_z", 3'b110, 1'b1, '{F, F, Z, Z, D,  DW, D, Z}, 2};

        rst        = 1'b0;
        bus.ena    = 1'b1;
        bus.opcode = 3'b101;
        bus.zero   = 1'b0;
        #1;
        probe("reset_outputs_ena1", Z);
        bus.ena = 1'b0;
        @(negedge clk1);
        probe("reset_outputs_ena0", Z);
        rst = 1'b1;
        @(negedge clk1);
        bus.ena = 1'b1;

        // Back-to-back instructions: each run also proves S7 wraps to S0.
        for (int i = 0; i < 9; i++) run_vec(i);

        // Enable dropped during S4 of ADD.
        bus.opcode = 3'b010;
        bus.zero   = 1'b0;
        step("add_s0", F);
        step("add_s1", F);
        step("add_s2", Z);
        step("add_s3", Z);
        probe("add_s4", R);
        bus.ena = 1'b0;
        probe("ena_drop_same_cycle", Z);
        @(negedge clk1);
        bus.ena = 1'b1;
        run_vec(5);

        // Reset pulsed during S1.
        bus.opcode = 3'b101;
        step("rstp_s0", F);
        probe("rstp_s1", F);
        rst = 1'b0;
        probe("rst_async_outputs", Z);
        @(negedge clk1);
        bus.ena = 1'b0;
        rst     = 1'b1;
        @(negedge clk1);
        bus.ena = 1'b1;
        run_vec(0);

        // HLT: halt from S4-time, strobes quiet, cleared only by reset.
        bus.opcode = 3'b000;
        bus.zero   = 1'b1;
        step("hlt_s0", F);
        step("hlt_s1", F);
        step("hlt_s2", Z);
        step("hlt_s3", Z);
        for (int c = 0; c < 20; c++) step($sformatf("halted_%0d", c), H);
        bus.opcode = 3'b101;
        step("halted_opcode_change", H);
        rst = 1'b0;
        probe("halt_cleared_async", Z);
        @(negedge clk1);
        bus.ena = 1'b0;
        rst     = 1'b1;
        @(negedge clk1);
        bus.ena = 1'b1;
        run_vec(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
